// File: rtl/tlm_slot_scheduler.sv
// rtl/tlm_slot_scheduler.sv - bit/half/frame strobe timebase with per-frame round-robin frame ownership
module tlm_slot_scheduler #(
    parameter int DIV_BIT = 126,
    parameter int SLOTS   = 80,
    parameter int FCW     = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_enable,
    input  logic [3:0]     i_req,
    output logic           o_bit_stb,
    output logic           o_half_stb,
    output logic           o_frame_stb,
    output logic [6:0]     o_slot_idx,
    output logic [FCW-1:0] o_frame_cnt,
    output logic [3:0]     o_grant,
    output logic           o_busy
);

    localparam int            PW         = (DIV_BIT > 2) ? $clog2(DIV_BIT) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(DIV_BIT - 1);
    localparam logic [6:0]    SLOT_LAST  = 7'(SLOTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STOPPING
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [PW-1:0]  r_phase;
    logic [6:0]     r_slot;
    logic [FCW-1:0] r_frame_cnt;
    logic [3:0]     r_grant;
    logic [1:0]     r_ptr;

    logic           w_running;
    logic           w_bit_stb;
    logic           w_frame_stb;
    logic [3:0]     w_arb_grant;
    logic [1:0]     w_arb_ptr;
    logic           w_arb_found;

    // Strobes decode registered state only, so they cannot glitch
    assign w_running   = (r_state != ST_IDLE);
    assign w_bit_stb   = w_running && (r_phase == PHASE_LAST);
    assign w_frame_stb = w_bit_stb && (r_slot == SLOT_LAST);

    assign o_bit_stb   = w_bit_stb;
    assign o_half_stb  = w_bit_stb && r_slot[0];
    assign o_frame_stb = w_frame_stb;
    assign o_slot_idx  = r_slot;
    assign o_frame_cnt = r_frame_cnt;
    assign o_grant     = r_grant;
    assign o_busy      = w_running;

    // Round-robin search starting at r_ptr, which points one past the last owner
    always_comb begin
        w_arb_grant = '0;
        w_arb_ptr   = r_ptr;
        w_arb_found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!w_arb_found && i_req[r_ptr + 2'(i)]) begin
                w_arb_found                 = 1'b1;
                w_arb_grant[r_ptr + 2'(i)]  = 1'b1;
                w_arb_ptr                   = r_ptr + 2'(i) + 2'd1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_enable) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (!i_enable) w_state_next = w_frame_stb ? ST_IDLE : ST_STOPPING;
            end
            ST_STOPPING: begin
                if (i_enable)         w_state_next = ST_RUN;
                else if (w_frame_stb) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_phase     <= '0;
            r_slot      <= '0;
            r_frame_cnt <= '0;
            r_grant     <= '0;
            r_ptr       <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE) begin
                if (i_enable) begin
                    r_grant <= w_arb_grant;
                    if (w_arb_found) r_ptr <= w_arb_ptr;
                end
            end else begin
                // Phase and slot wrap to 0 on the final frame_stb, so IDLE entry leaves them cleared
                r_phase <= w_bit_stb ? '0 : r_phase + PW'(1);
                if (w_bit_stb) r_slot <= (r_slot == SLOT_LAST) ? '0 : r_slot + 7'd1;
                if (w_frame_stb) begin
                    r_frame_cnt <= r_frame_cnt + FCW'(1);
                    if (w_state_next == ST_IDLE) begin
                        r_grant <= '0;
                    end else begin
                        r_grant <= w_arb_grant;
                        if (w_arb_found) r_ptr <= w_arb_ptr;
                    end
                end
            end
        end
    end

endmodule

// File: doc/tlm_slot_scheduler.md
# tlm_slot_scheduler

Frame and slot scheduler for the telemetry timebase. Running on the 80.64 MHz system clock, it produces phase-aligned single-cycle strobes at 640 kHz (bit), 320 kHz (half-rate) and 8 kHz (frame), along with the slot index and frame count. It also arbitrates frame ownership among up to four data sources with per-frame round-robin. All downstream serializers use these strobes as clock enables in place of divided clocks.

## Interface

- DIV_BIT, 126: clk cycles per bit slot (80.64 MHz / 640 kHz); legal ≥ 2
- SLOTS, 80: bit slots per frame (640 kHz / 8 kHz); legal: even, ≥ 2
- FCW, 16: frame counter width

- clk  in  1  system clock, 80.64 MHz
- reset  in  1  asynchronous, active-low
- enable  in  1  run request, level-sensitive, synchronous to clk
- req  in  4  per-source frame requests, level
- bit_stb  out  1  one-cycle strobe per bit slot
- half_stb  out  1  one-cycle strobe every second bit slot
- frame_stb  out  1  one-cycle strobe at end of frame
- slot_idx  out  7  current slot, 0..SLOTS-1
- frame_cnt  out  FCW  completed frames, wraps
- grant  out  4  one-hot frame owner, or 0
- busy  out  1  high when state ≠ IDLE

## Operation

- Internal counters:
  - phase: 0..DIV_BIT-1, increments every cycle while running.
  - slot_idx: advances when phase wraps.
  - frame_cnt: advances when slot_idx wraps.
- States and transitions:
  - IDLE: counters held at 0, grant = 0. Goes to RUN when enable = 1.
  - RUN: counters active. Goes to STOPPING when enable = 0.
  - STOPPING: counters stay active. Goes back to RUN if enable = 1 (the stop is cancelled with no discontinuity). Goes to IDLE on the cycle frame_stb is asserted, provided enable = 0 in that cycle.
- Strobe decoding:
  - bit_stb = running & (phase == DIV_BIT-1).
  - half_stb = bit_stb & slot_idx[0].
  - frame_stb = bit_stb & (slot_idx == SLOTS-1).
  - All three come from registered state and are glitch-free. They are never asserted in IDLE.
- Arbitration:
  - Grant is recomputed at IDLE→RUN entry and on every frame_stb edge.
  - Search order starts at the index after the last non-zero grant (pointer reset value 0, so search starts at index 0).
  - The first asserted req wins. If no req is asserted, grant = 0 for the next frame.
  - Grant is constant for the whole frame. Dropping req mid-frame does not revoke the grant.
- Stop behaviour:
  - On entry to IDLE: phase, slot_idx and grant clear.
  - frame_cnt and the round-robin pointer are retained. Only reset clears them.
- Width rules:
  - frame_cnt wraps from 2^FCW-1 to 0.
  - slot_idx wraps from SLOTS-1 to 0.
  - slot_idx is 7 bits. SLOTS must be ≤ 128.

## Timing

- Reset values: state IDLE; all outputs 0; pointer 0.
- Reset is asynchronous assert. Mid-frame reset forces every output low immediately, with no completion of the frame.
- Start:
  - enable is sampled high in IDLE at edge N.
  - From N: busy = 1, phase = 0, slot_idx = 0, grant valid.
  - First bit_stb in cycle N+DIV_BIT-1.
  - First frame_stb in cycle N + DIV_BIT·SLOTS - 1.
- Steady state:
  - bit_stb period DIV_BIT.
  - half_stb period 2·DIV_BIT, coincident with odd-slot bit_stb.
  - frame_stb period DIV_BIT·SLOTS (10080 cycles at defaults).
- Edge updates:
  - slot_idx, frame_cnt and grant update on the edge ending the strobe cycle.
  - The new values are visible in the first cycle of the next slot/frame.
- Stop:
  - busy falls on the edge ending the frame_stb cycle.
  - Latency from enable fall is at most one frame.
- Simultaneous events: enable falling in the frame_stb cycle causes direct RUN→IDLE after that frame, with no STOPPING state.

## Test plan

- Reset check. Assert reset while running mid-frame, then deassert with enable = 0.
  - Required: all outputs 0, busy = 0, no strobes for 20000 cycles.
- Default rates. DIV_BIT = 126, SLOTS = 80; enable = 1 at edge N.
  - Required: bit_stb at N+125, N+251, …
  - Required: half_stb only at N+251 + 252k.
  - Required: frame_stb at N+10079; frame_cnt = 1 after that edge.
- Round-robin arbitration. req = 4'b1011 held constant.
  - Required: grant sequence 0001, 0010, 1000, 0001 over successive frames.
  - Then req = 0. Required: grant = 0 next frame.
  - Then drop req mid-frame. Required: grant unchanged until frame end.
- Graceful stop and stop cancel.
  - enable falls at slot 10. Required: strobes continue; busy falls after frame_stb; slot_idx = 0; frame_cnt retained.
  - Repeat with enable reasserted at slot 40. Required: no gap in the strobe pattern.
- Wrap with small parameters. DIV_BIT = 2, SLOTS = 2, FCW = 4.
  - Run 17 frames. Required: frame_cnt goes 15→0 at frame 16, then 1.
  - Required: slot_idx alternates 0/1; half_stb coincides with frame_stb.
- Enable falling in the frame_stb cycle. Required: busy = 0 on the following cycle, and no extra frame.
